// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file: FSM encoding,
// byte-lane width and the data-width legality check.
package reg_file_2r1w_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

    localparam int unsigned BYTE_W = 8;

    // True when the word width is a non-zero whole number of byte lanes.
    function automatic bit width_ok(input int unsigned w);
        return (w != 0) && ((w % BYTE_W) == 0);
    endfunction

endpackage : reg_file_2r1w_pkg

// File: rtl/reg_file_if.sv
// Write/read bus of the register file; master drives requests, slave answers.
interface reg_file_if
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_W;

    logic                  clr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_data;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  busy;

    modport master (
        output clr, wr_en, w_addr, w_be, w_data, r_addr0, r_addr1,
        input  r_data0, r_data1, busy
    );

    modport slave (
        input  clr, wr_en, w_addr, w_be, w_data, r_addr0, r_addr1,
        output r_data0, r_data1, busy
    );

endinterface : reg_file_if

// File: rtl/reg_file_2r1w_clr_seq.sv
// Clear sequencer: walks every entry once after reset or a clear request,
// issuing one zero-write per cycle while busy.
module reg_file_2r1w_clr_seq
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // A clear request in IDLE only arms the walk; zeroing starts next edge.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (&clr_ptr_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    // Zero-writes happen on exactly the cycles the sequencer reports busy.
    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = clr_ptr_q;

endmodule : reg_file_2r1w_clr_seq

// File: rtl/reg_file_2r1w.sv
// Register file with one byte-enabled write port, two registered read ports
// with write-to-read bypass, and a self-clearing sequencer.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_W;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if (!width_ok(DATA_WIDTH)) begin : g_width_check
        $error("reg_file_2r1w: DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_data0_q, r_data0_d;
    logic [DATA_WIDTH-1:0] r_data1_q, r_data1_d;
    logic [DATA_WIDTH-1:0] wr_merged_c;
    logic                  wr_fire_c;
    logic                  seq_busy;
    logic                  seq_clr_we;
    logic [ADDR_WIDTH-1:0] seq_clr_addr;

    reg_file_2r1w_clr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (bus.clr),
        .busy_o     (seq_busy),
        .clr_we_o   (seq_clr_we),
        .clr_addr_o (seq_clr_addr)
    );

    assign wr_fire_c = bus.wr_en && !seq_clr_we;

    // Full word that a write would leave in the addressed entry.
    always_comb begin
        wr_merged_c = mem_q[bus.w_addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (bus.w_be[i]) begin
                wr_merged_c[i*BYTE_W +: BYTE_W] = bus.w_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (seq_clr_we) begin
                mem_q[seq_clr_addr] <= '0;
            end else if (wr_fire_c) begin
                mem_q[bus.w_addr] <= wr_merged_c;
            end
        end
    end

    // Reads return zero while clearing and forward a same-edge write.
    always_comb begin
        r_data0_d = '0;
        r_data1_d = '0;
        if (!seq_clr_we) begin
            r_data0_d = (wr_fire_c && (bus.w_addr == bus.r_addr0)) ? wr_merged_c
                                                                     : mem_q[bus.r_addr0];
            r_data1_d = (wr_fire_c && (bus.w_addr == bus.r_addr1)) ? wr_merged_c
                                                                     : mem_q[bus.r_addr1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data0_q <= '0;
            r_data1_q <= '0;
        end else begin
            r_data0_q <= r_data0_d;
            r_data1_q <= r_data1_d;
        end
    end

    assign bus.r_data0 = r_data0_q;
    assign bus.r_data1 = r_data1_q;
    assign bus.busy    = seq_busy;

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: a 16x4 instance for the main checks
// and a 16x8 instance for reset in the middle of a clear.
module tb_reg_file_2r1w;

    localparam int unsigned M_ALL = 7;

    logic clk = 1'b0;
    logic reset2 = 1'b1;
    logic reset3 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) b2 ();
    reg_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b3 ();

    reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (b2.slave)
    );

    reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (b3.slave)
    );

    typedef struct {
        int          due;
        int          dsel;
        logic [2:0]  mask;
        logic        eb;
        logic [15:0] e0;
        logic [15:0] e1;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t it;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs on the chosen DUT and queue the outputs it must show afterwards.
    task automatic step(input int dsel, input int rst, input int clr, input int we,
                        input int wa, input int be, input int wd,
                        input int ra0, input int ra1, input int mask,
                        input int eb, input int e0, input int e1, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (dsel == 0) begin
            reset2     = 1'(rst);
            b2.clr     = 1'(clr);
            b2.wr_en   = 1'(we);
            b2.w_addr  = 2'(wa);
            b2.w_be    = 2'(be);
            b2.w_data  = 16'(wd);
            b2.r_addr0 = 2'(ra0);
            b2.r_addr1 = 2'(ra1);
        end else begin
            reset3     = 1'(rst);
            b3.clr     = 1'(clr);
            b3.wr_en   = 1'(we);
            b3.w_addr  = 3'(wa);
            b3.w_be    = 2'(be);
            b3.w_data  = 16'(wd);
            b3.r_addr0 = 3'(ra0);
            b3.r_addr1 = 3'(ra1);
        end
        e.due  = cyc + 1;
        e.dsel = dsel;
        e.mask = 3'(mask);
        e.eb   = 1'(eb);
        e.e0   = 16'(e0);
        e.e1   = 16'(e1);
        e.nm   = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs settle after each rising edge; compare on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            if (it.dsel == 0) begin
                if (it.mask[2]) chk({it.nm, ".busy"}, {15'b0, b2.busy}, {15'b0, it.eb});
                if (it.mask[1]) chk({it.nm, ".r_data0"}, b2.r_data0, it.e0);
                if (it.mask[0]) chk({it.nm, ".r_data1"}, b2.r_data1, it.e1);
            end else begin
                if (it.mask[2]) chk({it.nm, ".busy"}, {15'b0, b3.busy}, {15'b0, it.eb});
                if (it.mask[1]) chk({it.nm, ".r_data0"}, b3.r_data0, it.e0);
                if (it.mask[0]) chk({it.nm, ".r_data1"}, b3.r_data1, it.e1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        {b2.clr, b2.wr_en, b2.w_addr, b2.w_be, b2.w_data, b2.r_addr0, b2.r_addr1} = '0;
        {b3.clr, b3.wr_en, b3.w_addr, b3.w_be, b3.w_data, b3.r_addr0, b3.r_addr1} = '0;

        // Reset and initial clear of the 4-entry instance
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, M_ALL, 1, 0, 0, "rst");
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 0, 0, 0, 0, i % 4, (i + 1) % 4, M_ALL, int'(i < 4), 0, 0, "rst_clr");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, M_ALL, 0, 0, 0, "rd01");
        step(0, 0, 0, 0, 0, 0, 0, 2, 3, M_ALL, 0, 0, 0, "rd23");

        // Byte enables
        step(0, 0, 0, 1, 1, 3, 16'hABCD, 0, 0, M_ALL, 0, 0, 0, "be_w1");
        step(0, 0, 0, 1, 1, 1, 16'h1234, 3, 3, M_ALL, 0, 0, 0, "be_w2");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, M_ALL, 0, 16'hAB34, 16'hAB34, "be_rd");

        // Bypass on both ports
        step(0, 0, 0, 1, 2, 3, 16'h5555, 0, 1, M_ALL, 0, 0, 16'hAB34, "byp_w1");
        step(0, 0, 0, 1, 2, 2, 16'hAAAA, 2, 2, M_ALL, 0, 16'hAA55, 16'hAA55, "byp_both");
        step(0, 0, 0, 0, 0, 0, 0, 2, 1, M_ALL, 0, 16'hAA55, 16'hAB34, "byp_rd");

        // Clear request followed by writes while busy
        step(0, 0, 1, 0, 0, 0, 0, 2, 2, M_ALL, 1, 16'hAA55, 16'hAA55, "clr_req");
        step(0, 0, 0, 1, 3, 3, 16'hFFFF, 3, 3, M_ALL, 1, 0, 0, "bw_e1");
        step(0, 0, 0, 1, 0, 3, 16'h1111, 0, 0, M_ALL, 1, 0, 0, "bw_e2");
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, M_ALL, 1, 0, 0, "bw_e3");
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, M_ALL, 0, 0, 0, "bw_e4");
        step(0, 0, 0, 0, 0, 0, 0, 3, 0, M_ALL, 0, 0, 0, "bw_rd30");
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, M_ALL, 0, 0, 0, "bw_rd12");

        // clr together with a write, extra clr pulses while busy
        step(0, 0, 1, 1, 0, 3, 16'h7777, 0, 3, M_ALL, 1, 16'h7777, 0, "clrwr");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 1, 0, 0, "cw_e1");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 1, 0, 0, "cw_e2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 1, 0, 0, "cw_e3");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, "cw_e4");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, "cw_rd0");

        // Empty and partial byte enables with bypass
        step(0, 0, 0, 1, 1, 0, 16'hBEEF, 1, 0, M_ALL, 0, 0, 0, "be00_byp");
        step(0, 0, 0, 1, 1, 2, 16'hC3A5, 0, 1, M_ALL, 0, 0, 16'hC300, "be10_byp");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, M_ALL, 0, 16'hC300, 16'hC300, "be_final");

        // 8-entry instance: reset, clear, fill upper entries
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, M_ALL, 1, 0, 0, "r3_rst");
        for (int i = 1; i <= 8; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, int'(i < 8), 0, 0, "r3_clr");
        step(1, 0, 0, 1, 5, 3, 16'h0505, 0, 0, M_ALL, 0, 0, 0, "r3_w5");
        step(1, 0, 0, 1, 6, 3, 16'h0606, 0, 0, M_ALL, 0, 0, 0, "r3_w6");
        step(1, 0, 0, 1, 7, 3, 16'h0707, 0, 0, M_ALL, 0, 0, 0, "r3_w7");
        step(1, 0, 0, 0, 0, 0, 0, 5, 7, M_ALL, 0, 16'h0505, 16'h0707, "r3_rd57");

        // Clear request, then reset once entries 0..4 are done (pointer at 5)
        step(1, 0, 1, 0, 0, 0, 0, 6, 6, M_ALL, 1, 16'h0606, 16'h0606, "r3_clrreq");
        for (int i = 1; i <= 5; i++)
            step(1, 0, 0, 0, 0, 0, 0, 6, 7, M_ALL, 1, 0, 0, "r3_part");
        step(1, 1, 0, 0, 0, 0, 0, 6, 7, M_ALL, 1, 0, 0, "r3_midrst");
        for (int i = 1; i <= 8; i++)
            step(1, 0, 0, 0, 0, 0, 0, 5, 6, M_ALL, int'(i < 8), 0, 0, "r3_reclr");
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 2 * i, 2 * i + 1, M_ALL, 0, 0, 0, "r3_rd");

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule : tb_reg_file_2r1w

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the codebase's simple register file.
- Provides one write port with byte enables and two independent synchronous read ports (1-cycle latency) with write-to-read bypass.
- A built-in clear sequencer zeroes every entry after reset or on request.
- Sits between the MP3 decoder control FSMs and the datapath as scratch/state storage, e.g. frame header fields and channel side-info.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 2, address width; DEPTH = 2**ADDR_WIDTH entries.
- NB (localparam), DATA_WIDTH/8, number of byte lanes.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  single-cycle request to zero all entries.
- wr_en  in  1  write strobe.
- w_addr  in  ADDR_WIDTH  write address.
- w_be  in  NB  byte-lane write enables; lane i = bits [8i+7:8i].
- w_data  in  DATA_WIDTH  write data.
- r_addr0  in  ADDR_WIDTH  read port 0 address.
- r_data0  out  DATA_WIDTH  read port 0 data, registered.
- r_addr1  in  ADDR_WIDTH  read port 1 address.
- r_data1  out  DATA_WIDTH  read port 1 data, registered.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- States: CLEAR, IDLE.
- Reset edge (reset=1 sampled):
  - state <= CLEAR, clr_ptr <= 0, busy <= 1.
  - r_data0 <= 0, r_data1 <= 0.
  - reset overrides every other input on that edge.
- CLEAR:
  - Each edge writes 0 to array[clr_ptr] and increments clr_ptr.
  - On the edge that clears entry DEPTH-1: state <= IDLE, busy <= 0.
  - After reset deasserts, busy stays high for exactly DEPTH edges.
- Reset while in CLEAR: restarts the sequence at clr_ptr=0.
- clr:
  - clr=1 in IDLE: next edge state <= CLEAR, clr_ptr <= 0, busy <= 1. No entry is zeroed on that edge; DEPTH further edges follow.
  - clr=1 while in CLEAR: ignored, no restart.
  - clr and wr_en together in IDLE: the write is performed, then cleared by the sequence.
- Write:
  - In IDLE with wr_en=1: for each lane i with w_be[i]=1, array[w_addr] lane i <= w_data lane i. Lanes with w_be[i]=0 keep their value.
  - w_be all zero is a legal no-op.
  - While busy, wr_en is ignored silently; no entry changes other than the clear.
- Read:
  - Each edge in IDLE: r_dataN <= array[r_addrN] (1-cycle latency).
  - Both ports are independent and may hit the same address.
- Bypass:
  - Applies when wr_en=1, state IDLE, and w_addr==r_addrN on the same edge.
  - r_dataN <= merged word: lanes with w_be=1 take w_data, other lanes take the old array value.
  - Reads never return stale data.
- Read while busy: r_data0/1 <= 0 on every edge in CLEAR, including the edge that clears the last entry.
- Outputs hold their value between edges; there are no combinational read paths.

Decomposition:
- Shared package/header reg_file_defs holds:
  - state encoding constants ST_CLEAR=1'b0, ST_IDLE=1'b1;
  - the lane-width constant BYTE_W=8;
  - the DATA_WIDTH%8 legality check macro.
- Sub-module reg_file_clr_seq (params ADDR_WIDTH) owns:
  - the CLEAR/IDLE FSM and clr_ptr counter;
  - outputs busy, clr_we, clr_addr.
- The top level holds the array, the byte-merge logic, the read registers and the bypass muxes.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=2 unless noted):
- Reset clear: pulse reset 1 cycle, then deassert.
  - busy=1 for exactly 4 edges, then 0.
  - r_data0/1=0x0000 throughout.
  - Afterwards, reading every address gives 0x0000.
- Byte enables:
  - Write addr1=0xABCD with be=2'b11, then addr1=0x1234 with be=2'b01.
  - r_addr0=1 reads 0xAB34 one cycle after the address is applied.
- Bypass on both ports: array[2]=0x5555, wr_en addr2 data 0xAAAA be=2'b10, r_addr0=r_addr1=2 on the same edge.
  - Both r_data = 0xAA55 on the next cycle.
- Writes during busy:
  - Assert clr, then in the next cycle wr_en addr3=0xFFFF.
  - busy=1 for 4 cycles; after busy falls, addr3 reads 0x0000.
- clr+wr_en same edge: write addr0=0x7777 with clr=1.
  - After the sequence, addr0 reads 0x0000.
  - clr pulses again while busy=1 do not extend busy beyond 4 cycles.
- Reset mid-clear (ADDR_WIDTH=3): assert reset at clr_ptr=5.
  - busy stays high 8 more edges after reset deasserts.
  - All 8 entries read 0.
